instr_loader: RTL and testbench

- Writer side of the instruction memory: accepts decoded instruction fields (opcode, reg1, reg2) over a valid/ready stream and packs each into a 9-bit word.
- Writes each word into consecutive instruction-memory addresses starting at 0, so test programs load at runtime instead of from a file.
- Sits between the testbench/host program source and the instruction memory write port.
- Packing is the exact inverse of the fetch-side split: word[8:6]=opcode, word[5:3]=reg1, word[2:0]=reg2.

---
 rtl/instr_pkg.sv | 21 ++
 rtl/instr_pack.sv | 16 +
 rtl/instr_loader.sv | 112 +++++++++++
 tb/tb_instr_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Instruction word layout shared by the loader (write side) and fetch (read side).
package instr_pkg;
  localparam int OP_BITS  = 3;
  localparam int REG_BITS = 3;
  localparam int INS_BITS = 9;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int R1_MSB = 5;
  localparam int R1_LSB = 3;
  localparam int R2_MSB = 2;
  localparam int R2_LSB = 0;

  typedef logic [INS_BITS-1:0] ins_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;
endpackage

// File: rtl/instr_pack.sv
// Packs decoded fields into an instruction word; exact inverse of the fetch-side split.
module instr_pack
  import instr_pkg::*;
(
  input  logic [OP_BITS-1:0]  op,
  input  logic [REG_BITS-1:0] reg1,
  input  logic [REG_BITS-1:0] reg2,
  output ins_t                word
);
  always_comb begin
    word                = '0;
    word[OP_MSB:OP_LSB] = op;
    word[R1_MSB:R1_LSB] = reg1;
    word[R2_MSB:R2_LSB] = reg2;
  end
endmodule

// File: rtl/instr_loader.sv
// Streams packed instruction words into instruction memory from address 0.
// Optional XOR checksum output enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import instr_pkg::*;
#(
  parameter int PC_BITS  = 12,
  parameter int INS_BITS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [2:0]          in_reg1,
  input  logic [2:0]          in_reg2,
  input  logic                in_last,
  output logic                mem_we,
  output logic [PC_BITS-1:0]  mem_addr,
  output logic [INS_BITS-1:0] mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                overflow,
`ifdef INSTR_LOADER_CHECKSUM_EN
  output logic [8:0]          checksum,
`endif
  output logic [PC_BITS:0]    count
);
  ld_state_t             state, state_nxt;
  ins_t                  word_p0;
  logic                  accept_p0, at_end_p0, restart_p0;
  logic [PC_BITS-1:0]    ptr;
  logic                  mem_we_p1;
  logic [PC_BITS-1:0]    mem_addr_p1;
  logic [INS_BITS-1:0]   mem_wdata_p1;
  logic [PC_BITS:0]      count_r;
  logic                  overflow_r;
  ins_t                  cks_r;

  instr_pack u_pack (
    .op   (in_op),
    .reg1 (in_reg1),
    .reg2 (in_reg2),
    .word (word_p0)
  );

  assign accept_p0  = in_valid && (state == LOAD);
  assign at_end_p0  = (ptr == {PC_BITS{1'b1}});
  assign restart_p0 = start && (state != LOAD);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept_p0 && (in_last || at_end_p0)) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state == LOAD);
    done     = (state == DONE);
  end

  // p0 -> p1: accepted beat becomes a registered memory write next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      ptr          <= '0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      cks_r        <= '0;
    end else begin
      mem_we_p1 <= accept_p0;
      if (restart_p0) begin
        ptr        <= '0;
        count_r    <= '0;
        overflow_r <= 1'b0;
        cks_r      <= '0;
      end else if (accept_p0) begin
        mem_addr_p1  <= ptr;
        mem_wdata_p1 <= word_p0;
        count_r      <= count_r + 1'b1;
        cks_r        <= cks_r ^ word_p0;
        // The pointer parks on the last address; the FSM leaves LOAD on this beat.
        if (!at_end_p0) ptr <= ptr + 1'b1;
        if (at_end_p0 && !in_last) overflow_r <= 1'b1;
      end
    end
  end

  assign mem_we    = mem_we_p1;
  assign mem_addr  = mem_addr_p1;
  assign mem_wdata = mem_wdata_p1;
  assign count     = count_r;
  assign overflow  = overflow_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum  = cks_r;
`else
  logic unused_cks;
  assign unused_cks = ^cks_r;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader using a small 16-word address space.
module tb_instr_loader;
  localparam int PCB   = 4;
  localparam int CW    = PCB + 1;
  localparam int DEPTH = 1 << PCB;

  logic           clk = 1'b0;
  logic           reset, start, in_valid, in_last;
  logic [2:0]     in_op, in_reg1, in_reg2;
  logic           in_ready, mem_we, busy, done, overflow;
  logic [PCB-1:0] mem_addr;
  logic [8:0]     mem_wdata;
  logic [PCB:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [8:0]     checksum;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int b_op [32];
  int b_r1 [32];
  int b_r2 [32];
  bit b_last [32];

  logic [PCB-1:0] wr_addr [$];
  logic [8:0]     wr_data [$];
  int             wr_cyc  [$];
  int             acc_cyc [$];

  instr_loader #(.PC_BITS(PCB), .INS_BITS(9)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef INSTR_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (in_valid && in_ready && !reset) acc_cyc.push_back(cyc);
  end

  function automatic int pack_ref(input int op, input int r1, input int r2);
    return op * 64 + r1 * 8 + r2;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic set_beat(input int i, input int op, input int r1, input int r2, input bit last);
    b_op[i] = op; b_r1[i] = r1; b_r2[i] = r2; b_last[i] = last;
  endtask

  // Offers beats 0..n-1 in order, one per cycle unless gaps, bounded by max_cyc.
  task automatic load(input int n, input bit gaps, input bit hold_start, input int max_cyc,
                      output int acc);
    int i = 0;
    int c = 0;
    bit hs;
    while (i < n && c < max_cyc) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_op    = 3'(b_op[i]);
      in_reg1  = 3'(b_r1[i]);
      in_reg2  = 3'(b_r2[i]);
      in_last  = b_last[i];
      start    = hold_start;
      @(negedge clk);
      hs = in_valid && in_ready;
      tick(1);
      if (hs) i++;
      c++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    acc = i;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if ({in_ready, busy, done, mem_we, overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {in_ready, busy, done, mem_we, overflow});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || count !== '0) begin
      failures++;
      $display("FAIL reset_regs got addr=%0h wdata=%0h count=%0d want 0/0/0", mem_addr, mem_wdata, count);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int acc;
    int bw = wr_addr.size();
    int ba = acc_cyc.size();
    int want [3] = '{9'h053, 9'h1C5, 9'h03F};
    int cks = 0;
    set_beat(0, 1, 2, 3, 0);
    set_beat(1, 7, 0, 5, 0);
    set_beat(2, 0, 7, 7, 1);
    pulse_start();
    load(3, 0, 0, 50, acc);
    tick(3);
    checks++;
    if (acc != 3 || wr_addr.size() - bw != 3) begin
      failures++;
      $display("FAIL basic_writes got acc=%0d writes=%0d want 3/3", acc, wr_addr.size() - bw);
    end else begin
      for (int k = 0; k < 3; k++) begin
        cks ^= pack_ref(b_op[k], b_r1[k], b_r2[k]);
        checks++;
        if (wr_addr[bw+k] !== PCB'(k) || int'(wr_data[bw+k]) != want[k] ||
            int'(wr_data[bw+k]) != pack_ref(b_op[k], b_r1[k], b_r2[k]) ||
            wr_cyc[bw+k] != acc_cyc[ba+k] + 1) begin
          failures++;
          $display("FAIL basic_word%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   k, wr_addr[bw+k], wr_data[bw+k], wr_cyc[bw+k], k, want[k], acc_cyc[ba+k] + 1);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== CW'(3) || overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_status got done=%b busy=%b count=%0d ovf=%b want 1/0/3/0", done, busy, count, overflow);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 9'h1A9 || int'(checksum) != cks) begin
      failures++;
      $display("FAIL basic_checksum got=%h want=1a9", checksum);
    end
`endif
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 5; r++) begin
      int acc;
      int n = $urandom_range(2, 9);
      int bw = wr_addr.size();
      int ba = acc_cyc.size();
      int cks = 0;
      for (int i = 0; i < n; i++)
        set_beat(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), i == n - 1);
      pulse_start();
      load(n, 1, 0, 400, acc);
      tick(3);
      checks++;
      if (acc != n || wr_addr.size() - bw != n) begin
        failures++;
        $display("FAIL gaps_r%0d_writes got acc=%0d writes=%0d want %0d", r, acc, wr_addr.size() - bw, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          cks ^= pack_ref(b_op[k], b_r1[k], b_r2[k]);
          checks++;
          if (wr_addr[bw+k] !== PCB'(k) || int'(wr_data[bw+k]) != pack_ref(b_op[k], b_r1[k], b_r2[k]) ||
              wr_cyc[bw+k] != acc_cyc[ba+k] + 1) begin
            failures++;
            $display("FAIL gaps_r%0d_word%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     r, k, wr_addr[bw+k], wr_data[bw+k], wr_cyc[bw+k], k,
                     pack_ref(b_op[k], b_r1[k], b_r2[k]), acc_cyc[ba+k] + 1);
          end
        end
      end
      checks++;
      if (done !== 1'b1 || count !== CW'(n) || overflow !== 1'b0) begin
        failures++;
        $display("FAIL gaps_r%0d_status got done=%b count=%0d ovf=%b want 1/%0d/0", r, done, count, overflow, n);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      checks++;
      if (int'(checksum) != cks) begin
        failures++;
        $display("FAIL gaps_r%0d_checksum got=%h want=%h", r, checksum, cks);
      end
`endif
    end
  endtask

  // v=0: 17 beats, never last; v=1: last coincides with the final address.
  task automatic test_overflow();
    for (int v = 0; v < 2; v++) begin
      int acc;
      int n = (v == 0) ? DEPTH + 1 : DEPTH;
      int bw = wr_addr.size();
      int bad = 0;
      for (int i = 0; i < n; i++)
        set_beat(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 (v == 1) && (i == n - 1));
      pulse_start();
      load(n, 0, 0, DEPTH + 6, acc);
      in_valid = 1'b1;
      tick(3);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ovf_v%0d_ready got=%b want=0", v, in_ready);
      end
      in_valid = 1'b0;
      tick(1);
      checks++;
      if (acc != DEPTH || wr_addr.size() - bw != DEPTH) begin
        failures++;
        $display("FAIL ovf_v%0d_writes got acc=%0d writes=%0d want %0d", v, acc, wr_addr.size() - bw, DEPTH);
      end else begin
        for (int k = 0; k < DEPTH; k++)
          if (wr_addr[bw+k] !== PCB'(k) || int'(wr_data[bw+k]) != pack_ref(b_op[k], b_r1[k], b_r2[k]))
            bad++;
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL ovf_v%0d_words got %0d bad words want 0", v, bad);
        end
      end
      checks++;
      if (done !== 1'b1 || count !== CW'(DEPTH) || overflow !== (v == 0)) begin
        failures++;
        $display("FAIL ovf_v%0d_status got done=%b count=%0d ovf=%b want 1/%0d/%0d",
                 v, done, count, overflow, DEPTH, v == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int bw = wr_addr.size();
    for (int i = 0; i < 4; i++)
      set_beat(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
    pulse_start();
    load(2, 0, 0, 20, acc);
    in_valid = 1'b1;
    in_op = 3'(b_op[2]); in_reg1 = 3'(b_r1[2]); in_reg2 = 3'(b_r2[2]);
    reset = 1'b1;
    tick(1);
    checks++;
    if (mem_we !== 1'b0 || {in_ready, busy, done, overflow} !== 4'b0 ||
        count !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got we=%b rdy=%b busy=%b done=%b ovf=%b count=%0d addr=%0d wdata=%h want all 0",
               mem_we, in_ready, busy, done, overflow, count, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    tick(3);
    checks++;
    if (acc != 2 || wr_addr.size() - bw != 2) begin
      failures++;
      $display("FAIL rstmid_writes got acc=%0d writes=%0d want 2", acc, wr_addr.size() - bw);
    end
    bw = wr_addr.size();
    set_beat(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1);
    pulse_start();
    load(1, 0, 0, 20, acc);
    tick(2);
    checks++;
    if (wr_addr.size() - bw != 1 || wr_addr[bw] !== '0 ||
        int'(wr_data[bw]) != pack_ref(b_op[0], b_r1[0], b_r2[0]) || count !== CW'(1)) begin
      failures++;
      $display("FAIL rstmid_restart got writes=%0d count=%0d want 1 write at addr 0 count=1",
               wr_addr.size() - bw, count);
    end
  endtask

  task automatic test_start_corners();
    int acc;
    int bw = wr_addr.size();
    int bad = 0;
    for (int i = 0; i < 3; i++)
      set_beat(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), i == 2);
    pulse_start();
    // start held through LOAD, including the cycle of the final accept
    load(3, 0, 1, 20, acc);
    tick(3);
    checks++;
    if (wr_addr.size() - bw != 3) begin
      failures++;
      $display("FAIL start_ignored_writes got=%0d want=3", wr_addr.size() - bw);
    end else begin
      for (int k = 0; k < 3; k++)
        if (wr_addr[bw+k] !== PCB'(k) || int'(wr_data[bw+k]) != pack_ref(b_op[k], b_r1[k], b_r2[k]))
          bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL start_ignored_words got %0d bad want 0", bad);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== CW'(3)) begin
      failures++;
      $display("FAIL start_last_done got done=%b busy=%b count=%0d want 1/0/3", done, busy, count);
    end
    bw = wr_addr.size();
    in_valid = 1'b1;
    tick(3);
    in_valid = 1'b0;
    tick(2);
    checks++;
    if (wr_addr.size() - bw != 0 || done !== 1'b1 || count !== CW'(3)) begin
      failures++;
      $display("FAIL done_hold got writes=%0d done=%b count=%0d want 0/1/3", wr_addr.size() - bw, done, count);
    end
    set_beat(0, 5, 0, 1, 1);
    pulse_start();
    load(1, 0, 0, 20, acc);
    tick(2);
    checks++;
    if (wr_addr.size() - bw != 1 || wr_addr[bw] !== '0 || wr_data[bw] !== 9'h141 ||
        count !== CW'(1) || done !== 1'b1) begin
      failures++;
      $display("FAIL reload got writes=%0d count=%0d done=%b want 1 write 141@0 count=1 done=1",
               wr_addr.size() - bw, count, done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_reg1 = '0; in_reg2 = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_reset_mid();
    test_start_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
